// File: rtl/rr_arbiter16.sv
// rtl/rr_arbiter16.sv - sixteen-requester round-robin arbiter with optional hold limit
module rr_arbiter16 #(
  parameter int MAX_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit          HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [15:0] gnt_nxt;
  logic [3:0]  idx_nxt;
  logic        pre_nxt;

  logic [15:0] arb_req;
  logic [3:0]  cand;
  logic [3:0]  win_idx;
  logic        win_found;
  logic        forced;
  logic        release_now;

  assign forced      = HOLD_EN && (state == GRANT) && (hold_cnt == HOLD_LAST);
  assign release_now = done || !req[gnt_idx] || forced;
  // a forcibly released owner must not immediately win again
  assign arb_req     = forced ? (req & ~gnt) : req;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = '0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!win_found && arb_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    pre_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = 16'h0001 << win_idx;
          idx_nxt   = win_idx;
          ptr_nxt   = win_idx + 4'd1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        pre_nxt = forced;
        if (release_now) begin
          if (win_found) begin
            gnt_nxt  = 16'h0001 << win_idx;
            idx_nxt  = win_idx;
            ptr_nxt  = win_idx + 4'd1;
            hold_nxt = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (hold_cnt != 8'hFF) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      preempt  <= pre_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule
